// File: rtl/move_input_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM per button,
// opposing-direction cancel, press-event pulses and a wrapping press counter.
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       dir_any,
  output logic [3:0] press_evt,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } db_state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // Bit order everywhere is {up, down, left, right}.
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] db;
  logic [3:0] db_seen_q;
  logic [3:0] dir_d, dir_q;
  logic [3:0] evt_q;
  logic [7:0] count_q;
  logic [7:0] evt_sum;

  db_state_e        state_q [4];
  db_state_e        state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  assign raw = {btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw};

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      db[i]      = (state_q[i] == StPressed) || (state_q[i] == StReleaseWait);
      case (state_q[i])
        StReleased: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntOne;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = CntOne;
          end
        end
        StReleaseWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // An opposing pair held together cancels to zero velocity on that axis.
  always_comb begin
    dir_d[3] = db[3] & ~db[2];
    dir_d[2] = db[2] & ~db[3];
    dir_d[1] = db[1] & ~db[0];
    dir_d[0] = db[0] & ~db[1];
  end

  assign evt_sum = 8'(evt_q[3]) + 8'(evt_q[2]) + 8'(evt_q[1]) + 8'(evt_q[0]);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dir_q     <= '0;
      dir_any   <= 1'b0;
      db_seen_q <= '0;
      evt_q     <= '0;
      count_q   <= '0;
    end else begin
      dir_q     <= dir_d;
      dir_any   <= |dir_d;
      db_seen_q <= db;
      evt_q     <= db & ~db_seen_q;
      count_q   <= count_q + evt_sum;
    end
  end

  assign up          = dir_q[3];
  assign down        = dir_q[2];
  assign left        = dir_q[1];
  assign right       = dir_q[0];
  assign press_evt   = evt_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES=4; expectations are
// queued when stimulus is driven and popped for comparison once the outputs settle.
module tb_move_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_r, down_r, left_r, right_r;
  logic       up, down, left, right, dir_any;
  logic [3:0] press_evt;
  logic [7:0] press_count;

  typedef struct {
    string      tag;
    logic [3:0] dirs;
    logic       any;
    logic [3:0] evt;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_cnt     = 0;

  always #5 clk = ~clk;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .btn_up_raw   (up_r),
    .btn_down_raw (down_r),
    .btn_left_raw (left_r),
    .btn_right_raw(right_r),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .dir_any      (dir_any),
    .press_evt    (press_evt),
    .press_count  (press_count)
  );

  task automatic push(input string tag, input logic [3:0] dirs, input logic [3:0] evt);
    exp_t e;
    e.tag  = tag;
    e.dirs = dirs;
    e.any  = |dirs;
    e.evt  = evt;
    e.cnt  = 8'(exp_cnt);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [3:0] obs_dirs;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      return;
    end
    e        = sb.pop_front();
    obs_dirs = {up, down, left, right};
    vectors++;
    assert (obs_dirs === e.dirs) else begin
      miscompares++;
      $error("FAIL %s dirs: got %b, expected %b", e.tag, obs_dirs, e.dirs);
    end
    vectors++;
    assert (dir_any === e.any) else begin
      miscompares++;
      $error("FAIL %s dir_any: got %b, expected %b", e.tag, dir_any, e.any);
    end
    vectors++;
    assert (press_evt === e.evt) else begin
      miscompares++;
      $error("FAIL %s press_evt: got %b, expected %b", e.tag, press_evt, e.evt);
    end
    vectors++;
    assert (press_count === e.cnt) else begin
      miscompares++;
      $error("FAIL %s press_count: got %0d, expected %0d", e.tag, press_count, e.cnt);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    up_r    = 1'b0;
    down_r  = 1'b0;
    left_r  = 1'b0;
    right_r = 1'b0;
    #3;
    push("reset", 4'b0000, 4'b0000);
    check();
    step(2);
    rst_n = 1'b1;

    // Clean press: outputs rise after edge 6.
    up_r = 1'b1;
    push("up_pre", 4'b0000, 4'b0000);
    step(6);
    check();
    push("up_rise", 4'b1000, 4'b1000);
    step(1);
    check();
    exp_cnt = 1;
    push("up_evt_clear", 4'b1000, 4'b0000);
    step(1);
    check();

    // Opposing cancel on the vertical axis.
    down_r = 1'b1;
    push("cancel_pre", 4'b1000, 4'b0000);
    step(6);
    check();
    push("cancel", 4'b0000, 4'b0100);
    step(1);
    check();
    exp_cnt = 2;
    push("cancel_cnt", 4'b0000, 4'b0000);
    step(1);
    check();
    down_r = 1'b0;
    push("restore_pre", 4'b0000, 4'b0000);
    step(6);
    check();
    push("restore_up", 4'b1000, 4'b0000);
    step(1);
    check();
    up_r = 1'b0;
    push("up_released", 4'b0000, 4'b0000);
    step(8);
    check();

    // Bounce and short pulse on left are rejected.
    for (int i = 0; i < 4; i++) begin
      left_r = ~i[0];
      push("bounce", 4'b0000, 4'b0000);
      step(1);
      check();
    end
    for (int i = 0; i < 10; i++) begin
      push("bounce_settle", 4'b0000, 4'b0000);
      step(1);
      check();
    end
    left_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("pulse3", 4'b0000, 4'b0000);
      step(1);
      check();
    end
    left_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("pulse3_settle", 4'b0000, 4'b0000);
      step(1);
      check();
    end

    // Release path on right: no event on release.
    right_r = 1'b1;
    push("right_pre", 4'b0000, 4'b0000);
    step(6);
    check();
    push("right_rise", 4'b0001, 4'b0001);
    step(1);
    check();
    exp_cnt = 3;
    push("right_held", 4'b0001, 4'b0000);
    step(1);
    check();
    right_r = 1'b0;
    push("rel_pre", 4'b0001, 4'b0000);
    step(6);
    check();
    push("rel_fall", 4'b0000, 4'b0000);
    step(1);
    check();
    push("rel_after", 4'b0000, 4'b0000);
    step(3);
    check();

    // Async reset while right is mid-debounce and left is asserted.
    left_r = 1'b1;
    exp_cnt = 4;
    push("left_held", 4'b0010, 4'b0000);
    step(8);
    check();
    right_r = 1'b1;
    push("pw_before_rst", 4'b0010, 4'b0000);
    step(4);
    check();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    push("async_rst", 4'b0000, 4'b0000);
    check();
    left_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("post_rst_hold", 4'b0000, 4'b0000);
    step(6);
    check();
    exp_cnt = 1;
    push("post_rst_right", 4'b0001, 4'b0000);
    step(2);
    check();
    right_r = 1'b0;
    push("post_rst_release", 4'b0000, 4'b0000);
    step(8);
    check();

    // Preload the counter to 254, then press all four at once to wrap.
    while (exp_cnt < 254) begin
      up_r = 1'b1;
      step(8);
      up_r = 1'b0;
      exp_cnt++;
      push("preload", 4'b0000, 4'b0000);
      step(8);
      check();
    end
    up_r    = 1'b1;
    down_r  = 1'b1;
    left_r  = 1'b1;
    right_r = 1'b1;
    push("all_pre", 4'b0000, 4'b0000);
    step(6);
    check();
    push("all_evt", 4'b0000, 4'b1111);
    step(1);
    check();
    exp_cnt = (254 + 4) % 256;
    push("wrap", 4'b0000, 4'b0000);
    step(1);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
